// File: rtl/sched_pkg.sv
// Shared types and helpers for the sense-change packet scheduler.
// Build option PKT_CHECKSUM_EN appends an XOR checksum byte to each packet.
package sched_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CHAN,
    ST_DATA,
    ST_CSUM
  } state_t;

  // Width of a counter holding values 0..n-1 (never less than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Channel-index FIFO with registered occupancy level.
// Pending flags upstream bound occupancy, so there is no full handling.
import sched_pkg::*;

module sched_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int PW = cnt_w(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic          w_pop;

  assign w_pop   = i_pop && (r_level != '0);
  assign o_head  = r_mem[r_rp];
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // Storage array; contents are qualified by the level, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (i_push)
        r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop)
        r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
      unique case ({i_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sense_change_scheduler.sv
// Detects sense-word changes beyond a deadband and emits paced packets.
// Define PKT_CHECKSUM_EN to append the XOR checksum byte after DATA.
import sched_pkg::*;

module sense_change_scheduler #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 24,
  parameter int DEADBAND = 0,
  parameter int PACE_DIV = 667
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*DATA_W-1:0]    sense_data,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic [$clog2(NUM_CH+1)-1:0] queue_level
);

  localparam int IW = cnt_w(NUM_CH);
  localparam int NB = DATA_W / 8;
  localparam int BW = cnt_w(NB);
  localparam int PW = cnt_w(PACE_DIV);

  logic [DATA_W-1:0] w_sense [NUM_CH];
  logic [DATA_W-1:0] r_snap  [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_clr;
  logic              w_push;
  logic [IW-1:0]     w_push_idx;
  logic [IW-1:0]     w_head;
  logic              w_empty;
  logic              w_launch;
  logic              w_acc;
  logic [7:0]        w_chan_byte;
  logic [PW-1:0]     r_pace;
  state_t            r_state;
  logic [7:0]        r_chan;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bcnt;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]        r_csum;

  // XOR of all bytes of a sense word.
  function automatic logic [7:0] xor_fold(input logic [DATA_W-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int b = 0; b < NB; b++) acc ^= v[b*8 +: 8];
    return acc;
  endfunction
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_sense[g] = sense_data[g*DATA_W +: DATA_W];
  end

  assign w_acc       = tx_valid && tx_ready;
  assign w_launch    = (r_state == ST_IDLE) && !w_empty && (r_pace == '0);
  assign w_chan_byte = 8'(w_head);
  assign busy        = (r_state != ST_IDLE);

  // Deadband compare per channel and lowest-index pick for the queue.
  always_comb begin
    logic [DATA_W-1:0] v_diff;
    v_diff     = '0;
    w_cand     = '0;
    w_push     = 1'b0;
    w_push_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v_diff = (w_sense[i] >= r_snap[i]) ? w_sense[i] - r_snap[i]
                                         : r_snap[i] - w_sense[i];
      w_cand[i] = (v_diff > DATA_W'(DEADBAND)) && !r_pend[i];
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_push     = 1'b1;
        w_push_idx = IW'(i);
      end
    end
    w_set = w_push   ? (NUM_CH'(1) << w_push_idx) : '0;
    w_clr = w_launch ? (NUM_CH'(1) << w_head)     : '0;
  end

  sched_fifo #(
    .DEPTH (NUM_CH),
    .W     (IW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_idx),
    .i_pop   (w_launch),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_level (queue_level)
  );

  // Pending flags and last-sent snapshots per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
    end else begin
      r_pend <= (r_pend | w_set) & ~w_clr;
      if (w_launch) r_snap[w_head] <= w_sense[w_head];
    end
  end

  // Launch pacing: reload on launch, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pace <= '0;
    else if (w_launch)
      r_pace <= PW'(PACE_DIV - 1);
    else if (r_pace != '0)
      r_pace <= r_pace - PW'(1);
  end

  // Packet framing FSM with registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      r_chan   <= '0;
      r_shift  <= '0;
      r_bcnt   <= '0;
`ifdef PKT_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_launch) begin
          r_state  <= ST_SYNC;
          tx_valid <= 1'b1;
          tx_data  <= SYNC_BYTE;
          r_chan   <= w_chan_byte;
          r_shift  <= w_sense[w_head];
`ifdef PKT_CHECKSUM_EN
          r_csum   <= w_chan_byte ^ xor_fold(w_sense[w_head]);
`endif
        end
        ST_SYNC: if (w_acc) begin
          r_state <= ST_CHAN;
          tx_data <= r_chan;
        end
        ST_CHAN: if (w_acc) begin
          r_state <= ST_DATA;
          tx_data <= r_shift[DATA_W-1 -: 8];
          r_shift <= r_shift << 8;
          r_bcnt  <= '0;
        end
        ST_DATA: if (w_acc) begin
          if (r_bcnt == BW'(NB - 1)) begin
`ifdef PKT_CHECKSUM_EN
            r_state  <= ST_CSUM;
            tx_data  <= r_csum;
`else
            r_state  <= ST_IDLE;
            tx_valid <= 1'b0;
`endif
          end else begin
            r_bcnt  <= r_bcnt + BW'(1);
            tx_data <= r_shift[DATA_W-1 -: 8];
            r_shift <= r_shift << 8;
          end
        end
        ST_CSUM: if (w_acc) begin
          r_state  <= ST_IDLE;
          tx_valid <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sense_change_scheduler.sv
// Scoreboard bench for sense_change_scheduler.
// Honours PKT_CHECKSUM_EN for packet length and checksum bytes.
`timescale 1ns/1ps

module tb_sense_change_scheduler;

  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 24;
  localparam int DEADBAND = 16;
  localparam int PACE_DIV = 20;
`ifdef PKT_CHECKSUM_EN
  localparam int PKT_LEN  = 6;
`else
  localparam int PKT_LEN  = 5;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] sense = '0;
  logic                     tx_ready = 1'b0;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     busy;
  logic [3:0]               queue_level;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         launch_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  sense_change_scheduler #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .DEADBAND (DEADBAND),
    .PACE_DIV (PACE_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sense_data  (sense),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .queue_level (queue_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [23:0] v);
    sense[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic exp_pkt(input int ch, input logic [23:0] v);
`ifdef PKT_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'(ch) ^ v[23:16] ^ v[15:8] ^ v[7:0];
`endif
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (exp_q.size() == 0 && !busy && !tx_valid) break;
      @(posedge clk);
    end
    chk(nm, 32'(k < 2000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_len(input string nm);
    int cnt;
    cnt = 0;
    while (tx_valid && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    chk(nm, 32'(cnt), 32'(PKT_LEN));
  endtask

  // Monitor: pops expected bytes on handshakes, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {23'b0, tx_valid, tx_data},
            {23'b0, 1'b1, prev_data});
      if (tx_valid && !prev_valid) launch_q.push_back(cyc);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte got=%02h want=none", tx_data);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_valid = tx_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset values
    step(3);
    @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(queue_level), 32'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // Single change on channel 3, back-to-back bytes
    tx_ready = 1'b1;
    set_ch(3, 24'h123456);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'h73);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("t1_level_push", 32'(queue_level), 32'd1);
    chk("t1_valid_wait", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_launch", 32'(tx_valid), 32'd1);
    chk("t1_level_pop", 32'(queue_level), 32'd0);
    measure_len("t1_len");
    wait_idle("t1_drain");
    step(PACE_DIV);

    // Deadband: 10 ignored, 17 sent
    set_ch(0, 24'd10);
    step(6);
    @(negedge clk);
    chk("t2_level_quiet", 32'(queue_level), 32'd0);
    chk("t2_busy_quiet", 32'(busy), 32'd0);
    step(1);
    set_ch(0, 24'h000011);
    exp_pkt(0, 24'h000011);
    wait_idle("t2_drain");
    step(PACE_DIV);

    // Channels 2 and 5 together: order and pacing
    launch_q.delete();
    set_ch(2, 24'h00AB00);
    set_ch(5, 24'h500000);
    exp_pkt(2, 24'h00AB00);
    exp_pkt(5, 24'h500000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t3_level_pushpop", 32'(queue_level), 32'd1);
    wait_idle("t3_drain");
    chk("t3_launches", 32'(launch_q.size()), 32'd2);
    if (launch_q.size() == 2)
      chk("t3_pace_gap", 32'(launch_q[1] - launch_q[0]), 32'(PACE_DIV));
    step(PACE_DIV);

    // Ready asserted one cycle in three
    set_ch(7, 24'hC0FFEE);
    exp_pkt(7, 24'hC0FFEE);
    for (int i = 0; i < 300; i++) begin
      if (i > 2 && exp_q.size() == 0 && !busy) break;
      tx_ready = (i % 3 == 0);
      @(posedge clk);
      #1;
    end
    chk("t4_drain", 32'(exp_q.size()), 32'd0);
    tx_ready = 1'b1;
    step(PACE_DIV);

    // Channel 1 moves twice while queued behind a stalled packet
    tx_ready = 1'b0;
    set_ch(4, 24'h000100);
    step(4);
    set_ch(1, 24'h111111);
    step(3);
    @(negedge clk);
    chk("t5_level_first", 32'(queue_level), 32'd1);
    step(1);
    set_ch(1, 24'h222222);
    step(3);
    @(negedge clk);
    chk("t5_level_dup", 32'(queue_level), 32'd1);
    exp_pkt(4, 24'h000100);
    exp_pkt(1, 24'h222222);
    step(1);
    tx_ready = 1'b1;
    wait_idle("t5_drain");
    step(PACE_DIV);

    // Reset during DATA
    set_ch(6, 24'hDEAD01);
    set_ch(7, 24'h000007);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'hDE);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'hDE) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reach_data", 32'(found), 32'd1);
    chk("t6_level_pre", 32'(queue_level), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid_async", 32'(tx_valid), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_level_async", 32'(queue_level), 32'd0);
    sense = '0;
    set_ch(6, 24'hDEAD01);
    step(3);
    rst = 1'b0;
    exp_pkt(6, 24'hDEAD01);
    wait_idle("t6_drain");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
